// File: rtl/keypad_matrix_scanner.sv
// Purpose : scans a ROWSxCOLS passive key matrix one column at a time and debounces the first key found.
// Latency : key_valid pulses one clock after the DEBOUNCE_COUNT-th consistent sample (9 clocks after detection with defaults).
// Backpressure: none; key_valid/key_release are single-cycle strobes and the consumer must take them when they fire.
//
// Ports:
//   clock        scan-rate clock
//   reset        synchronous, active-high
//   row_sense    row lines, active-high, already synchronised
//   col_drive    one-hot active-high column drive
//   key_code     code of last accepted key = col*ROWS + row
//   key_valid    one-cycle pulse on accepted press
//   key_down     high while the accepted key is held
//   key_release  one-cycle pulse on accepted release
module keypad_matrix_scanner #(
    parameter int COLS           = 4,
    parameter int ROWS           = 4,
    parameter int SETTLE_CYCLES  = 4,
    parameter int DEBOUNCE_COUNT = 3,
    parameter int CODE_W         = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ROWS-1:0]   row_sense,
    output logic [COLS-1:0]   col_drive,
    output logic [CODE_W-1:0] key_code,
    output logic              key_valid,
    output logic              key_down,
    output logic              key_release
);

    localparam int COL_W   = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int ROW_W   = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int DWELL_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int CNT_W   = $clog2(DEBOUNCE_COUNT + 1);

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [COL_W-1:0]    col_q, col_d;
    logic [ROW_W-1:0]    row_q, row_d;
    logic [DWELL_W-1:0]  dwell_q, dwell_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [CODE_W-1:0]   code_q, code_d;
    logic                valid_q, valid_d;
    logic                down_q, down_d;
    logic                rel_q, rel_d;

    logic                sample;
    logic [COL_W-1:0]    col_next;
    logic [CNT_W-1:0]    cnt_inc;
    logic [ROW_W-1:0]    low_row;

    // Dwell runs free in every state; the last cycle of each dwell is the sample point.
    assign sample   = (dwell_q == DWELL_W'(SETTLE_CYCLES - 1));
    assign col_next = (col_q == COL_W'(COLS - 1)) ? '0 : col_q + COL_W'(1);
    assign cnt_inc  = cnt_q + CNT_W'(1);

    // Lowest set row bit wins when several keys share the driven column.
    always_comb begin
        low_row = '0;
        for (int i = ROWS - 1; i >= 0; i--) begin
            if (row_sense[i]) begin
                low_row = ROW_W'(i);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= SCAN;
            col_q   <= '0;
            row_q   <= '0;
            dwell_q <= '0;
            cnt_q   <= '0;
            code_q  <= '0;
            valid_q <= 1'b0;
            down_q  <= 1'b0;
            rel_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            dwell_q <= dwell_d;
            cnt_q   <= cnt_d;
            code_q  <= code_d;
            valid_q <= valid_d;
            down_q  <= down_d;
            rel_q   <= rel_d;
        end
    end

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        cnt_d   = cnt_q;
        code_d  = code_q;
        down_d  = down_q;
        valid_d = 1'b0;
        rel_d   = 1'b0;
        dwell_d = sample ? '0 : dwell_q + DWELL_W'(1);

        case (state_q)
            SCAN: begin
                if (sample) begin
                    if (row_sense == '0) begin
                        col_d = col_next;
                    end else begin
                        row_d   = low_row;
                        cnt_d   = CNT_W'(1);
                        state_d = DEBOUNCE;
                    end
                end
            end
            DEBOUNCE: begin
                if (sample) begin
                    if (row_sense[row_q]) begin
                        if (cnt_inc == CNT_W'(DEBOUNCE_COUNT)) begin
                            code_d  = CODE_W'(col_q) * CODE_W'(ROWS) + CODE_W'(row_q);
                            valid_d = 1'b1;
                            down_d  = 1'b1;
                            cnt_d   = '0;   // reused as the release count in HELD
                            state_d = HELD;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end else begin
                        // Bounce: drop the candidate and carry on from the next column.
                        cnt_d   = '0;
                        col_d   = col_next;
                        state_d = SCAN;
                    end
                end
            end
            HELD: begin
                if (sample) begin
                    if (!row_sense[row_q]) begin
                        if (cnt_inc == CNT_W'(DEBOUNCE_COUNT)) begin
                            down_d  = 1'b0;
                            rel_d   = 1'b1;
                            cnt_d   = '0;
                            col_d   = col_next;
                            state_d = SCAN;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end else begin
                        // Any reappearance of the key restarts the release qualification.
                        cnt_d = '0;
                    end
                end
            end
            default: begin
                state_d = SCAN;
            end
        endcase
    end

    always_comb begin
        col_drive        = '0;
        col_drive[col_q] = 1'b1;
    end

    assign key_code    = code_q;
    assign key_valid   = valid_q;
    assign key_down    = down_q;
    assign key_release = rel_q;

endmodule
